// File: rtl/tour_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// tour_cmd_sequencer_if
// Link between the command sequencer and the RemoteComm transmitter.
//   cmd      : 16-bit Knight command presented to RemoteComm
//   snd_cmd  : one-cycle send strobe
//   cmd_snt  : RemoteComm finished shifting out both command bytes
//   resp_rdy : one-cycle pulse, resp is valid
//   resp     : response byte returned by the Knight
// master = sequencer side, slave = RemoteComm side.
// ---------------------------------------------------------------------------
interface tour_cmd_sequencer_if;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        cmd_snt;
  logic        resp_rdy;
  logic [7:0]  resp;

  modport master (
    output cmd,
    output snd_cmd,
    input  cmd_snt,
    input  resp_rdy,
    input  resp
  );

  modport slave (
    input  cmd,
    input  snd_cmd,
    output cmd_snt,
    output resp_rdy,
    output resp
  );
endinterface

// File: rtl/tour_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tour_cmd_sequencer
// Buffers a list of 16-bit Knight commands and replays them one at a time to
// RemoteComm, waiting for the acknowledge byte after each command.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   wr_en, wr_cmd   : push a command into the circular queue
//   start           : begin draining the queue (IDLE only)
//   abort           : stop the sequence and flush the queue (not in IDLE)
//   link (master)   : cmd/snd_cmd out, cmd_snt/resp_rdy/resp in
//   busy            : sequence in progress (ISSUE, WAIT_SNT, WAIT_RESP)
//   done            : one-cycle pulse after the last command is acknowledged
//   err, err_code   : sticky error; 1 = NAK, 2 = timeout, 3 = overflow
//   count           : commands acknowledged in the current sequence
//   level           : queue occupancy
// ---------------------------------------------------------------------------
module tour_cmd_sequencer #(
  parameter int         DEPTH = 32,
  parameter logic [7:0] ACK   = 8'hA5,
  parameter int         TMO_W = 26
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [15:0]              wr_cmd,
  input  logic                     start,
  input  logic                     abort,
  tour_cmd_sequencer_if.master     link,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [7:0]               count,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_SNT, S_WAIT_RESP, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        cmd_q, cmd_d;
  logic               snd_q, snd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;
  logic [7:0]         count_q, count_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               snt_prev_q, snt_prev_d;

  // Queue storage carries data only, so it is not reset.
  logic [15:0]        fifo_mem [DEPTH];

  logic               full, push, pop, flush, snt_rise;
  logic [TMO_W-1:0]   tmo_nxt;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    snd_d      = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    code_d     = code_q;
    count_d    = count_q;
    tmo_d      = tmo_q;
    pop        = 1'b0;
    flush      = 1'b0;
    snt_prev_d = link.cmd_snt;
    full       = (level_q == LVL_W'(DEPTH));
    // Edge detect: a cmd_snt level already high on entry is not a new event.
    snt_rise   = link.cmd_snt & ~snt_prev_q;
    tmo_nxt    = tmo_q + TMO_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d  = 1'b0;
          code_d = 2'd0;
          if (level_q != '0) begin
            count_d = '0;
            state_d = S_ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        pop     = 1'b1;
        cmd_d   = fifo_mem[rd_ptr_q];
        snd_d   = 1'b1;
        tmo_d   = '0;
        state_d = S_WAIT_SNT;
      end
      S_WAIT_SNT: begin
        tmo_d = '0;
        if (snt_rise) state_d = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        tmo_d = tmo_nxt;
        if (link.resp_rdy) begin
          if (link.resp == ACK) begin
            if (count_q != 8'hFF) count_d = count_q + 8'd1;
            state_d = (level_q != '0) ? S_ISSUE : S_DONE;
          end else begin
            err_d   = 1'b1;
            code_d  = 2'd1;
            state_d = S_IDLE;
          end
        end else if (tmo_nxt == '1) begin
          // Counter reaches all-ones on the same edge the timeout is taken.
          err_d   = 1'b1;
          code_d  = 2'd2;
          state_d = S_IDLE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every transition above, including any error or count
    // update from the same cycle.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      flush   = 1'b1;
      pop     = 1'b0;
      snd_d   = 1'b0;
      cmd_d   = cmd_q;
      err_d   = err_q;
      code_d  = code_q;
      count_d = count_q;
      tmo_d   = '0;
    end

    if (state_d == S_DONE) done_d = 1'b1;

    push = wr_en & ~full & ~flush;
    if (wr_en && full && !flush) begin
      err_d  = 1'b1;
      code_d = 2'd3;
    end

    if (flush) begin
      level_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end

    busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT_SNT) ||
             (state_d == S_WAIT_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      snd_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= 2'd0;
      count_q    <= '0;
      level_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      tmo_q      <= '0;
      snt_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      snd_q      <= snd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      code_q     <= code_d;
      count_q    <= count_d;
      level_q    <= level_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      tmo_q      <= tmo_d;
      snt_prev_q <= snt_prev_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= wr_cmd;
  end

  assign link.cmd     = cmd_q;
  assign link.snd_cmd = snd_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign err_code     = code_q;
  assign count        = count_q;
  assign level        = level_q;
endmodule

// File: doc/tour_cmd_sequencer.md
# tour_cmd_sequencer

Host-side command sequencer for the Knight's Tour system. It buffers a list of 16-bit Knight commands (for example calibrate, move, move-with-fanfare) and issues them one at a time to the RemoteComm transmitter. After each command it waits for the DUT's acknowledge byte before sending the next, so a full tour can be replayed without a per-move testbench script. It sits directly upstream of RemoteComm and feeds its `cmd`/`snd_cmd` inputs while consuming `cmd_snt`, `resp_rdy` and `resp`.

## Interface
- `DEPTH`, default 32: command queue entries. Must be a power of two, 2..256.
- `ACK`, default 8'hA5: expected positive-acknowledge byte.
- `TMO_W`, default 26: width of the response timeout counter. The timeout fires at 2^TMO_W − 1 cycles.
- `clk` input, 1: system clock. Single clock domain.
- `rst` input, 1: reset. Synchronous and active-high.
- `wr_en` input, 1: push `wr_cmd` into the queue.
- `wr_cmd` input, 16: command to enqueue.
- `start` input, 1: begin draining the queue. Honoured only in IDLE.
- `abort` input, 1: stop the sequence and go to IDLE. The queue is flushed.
- `cmd` output, 16: command presented to RemoteComm.
- `snd_cmd` output, 1: one-cycle send strobe to RemoteComm.
- `cmd_snt` input, 1: RemoteComm has finished transmitting both command bytes.
- `resp_rdy` input, 1: response byte is valid. One-cycle pulse.
- `resp` input, 8: response byte.
- `busy` output, 1: a sequence is in progress.
- `done` output, 1: one-cycle pulse when the last command has been acknowledged.
- `err` output, 1: sticky error flag. Cleared by `start` or `rst`.
- `err_code` output, 2: 0 = none, 1 = NAK (wrong response byte), 2 = timeout, 3 = overflow.
- `count` output, 8: number of commands acknowledged in the current sequence.
- `level` output, $clog2(DEPTH)+1: current queue occupancy.

## Operation
- **Queue.** Circular buffer with separate read and write pointers plus an occupancy counter.
  - Push when `wr_en` and not full.
  - `wr_en` while full: the data is dropped, `err` is set and `err_code` is 3. The sequencer state is unaffected.
  - Pushes are accepted in any state, so the queue can be refilled while a sequence is running.
  - A push and a pop in the same cycle leave `level` unchanged.
- **FSM states:** IDLE, ISSUE, WAIT_SNT, WAIT_RESP, DONE.
- **IDLE.**
  - `start` with `level` > 0: clear `err`, `err_code` and `count`, then go to ISSUE.
  - `start` with `level` = 0: assert the `done` pulse next cycle and stay in IDLE.
- **ISSUE.** Pop the head entry into the `cmd` register, pulse `snd_cmd` for exactly one cycle, go to WAIT_SNT.
- **WAIT_SNT.** Go to WAIT_RESP on `cmd_snt` rising. The timeout counter is cleared on entry.
- **WAIT_RESP.**
  - `resp_rdy` with `resp` == ACK: increment `count` (saturating at 255). If `level` > 0 go to ISSUE; otherwise go to DONE.
  - `resp_rdy` with any other byte: `err` = 1, `err_code` = 1, go to IDLE. The queue is retained so the host can inspect or retry.
  - Timeout counter reaching all-ones: `err` = 1, `err_code` = 2, go to IDLE.
- **DONE.** Pulse `done` for one cycle, then go to IDLE.
- **`abort`.** Valid in any state except IDLE. Next state is IDLE, the queue is flushed (pointers and `level` to 0), and `err` is unchanged. `abort` has priority over every other transition and over `wr_en` in the same cycle.
- **Outputs.**
  - `cmd` holds its last value until the next ISSUE.
  - `busy` = 1 in ISSUE, WAIT_SNT and WAIT_RESP.

## Timing
- All outputs are registered.
- Reset values: FSM IDLE, `cmd` = 16'h0000, `snd_cmd` = 0, `busy` = 0, `done` = 0, `err` = 0, `err_code` = 0, `count` = 0, `level` = 0, pointers = 0.
- Latency from `start` (sampled) to `snd_cmd` high: 2 cycles (IDLE→ISSUE, then the strobe registered on exit from ISSUE). `cmd` is valid in the same cycle as `snd_cmd` and stays stable until the next command.
- Latency from the accepting ACK to the next `snd_cmd`: 2 cycles.
- `cmd_snt` rising is detected with a one-flop edge detector, so a level that is already high on entry to WAIT_SNT does not count.
- `resp_rdy` arriving in WAIT_SNT is ignored.
- `rst` asserted mid-sequence returns every register to its reset value on the next edge. An in-flight RemoteComm transfer is not cancelled by this block.
- Simultaneous `start` and `abort` in IDLE: `start` wins, because `abort` is a no-op in IDLE.

## Test plan
- **Single command.** Push 16'h2000, `start`, RemoteComm returns A5 → one `snd_cmd` with `cmd` = 16'h2000; `done` pulses; `count` = 1; `err` = 0.
- **Four-move L sequence.** Push 16'h4002, 16'h5BF1, 16'h47F1, 16'h53F2 and run against the full KnightsTour + KnightPhysics model → commands are issued in order, each only after the previous A5; `count` = 4; the knight ends at (0,2).
- **NAK.** Second response is 8'h5A → `err` = 1, `err_code` = 1, state IDLE, `count` = 1, `level` = remaining entries.
- **Timeout.** Run with TMO_W = 8 and `resp_rdy` never asserted → `err_code` = 2 exactly 255 cycles after WAIT_RESP entry; `busy` falls.
- **Overflow.** Run with DEPTH = 4 and push 5 entries → `level` = 4, `err_code` = 3; draining issues only the first 4 commands.
- **Abort and reset mid-run.** Assert `abort` in WAIT_RESP → IDLE, `level` = 0, no further `snd_cmd`. Assert `rst` in WAIT_SNT → all outputs return to their reset values on the next edge.
